// File: rtl/heap_alloc_pkg.sv
// Shared types and constants for the Lisp heap allocator: object headers,
// primitive codes, allocator states and object sizes.
package heap_alloc_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_HEAP_BASE  = 12'h100;
  localparam logic [ADDR_W-1:0] DEFAULT_HEAP_LIMIT = 12'hFFF;
  localparam logic [ADDR_W-1:0] NIL                = 12'h000;

  typedef enum logic [7:0] {
    HDR_NUMBER    = 8'h00,
    HDR_CONS      = 8'h01,
    HDR_FUNC_PRIM = 8'h02
  } header_t;

  typedef enum logic [7:0] {
    PRIM_CAR  = 8'h01,
    PRIM_CDR  = 8'h02,
    PRIM_ATOM = 8'h03,
    PRIM_EQ   = 8'h04
  } primitive_t;

  typedef enum logic [1:0] {
    ALLOC_IDLE  = 2'd0,
    ALLOC_WRITE = 2'd1,
    ALLOC_RESP  = 2'd2
  } alloc_state_t;

  localparam logic [2:0] NUMBER_SIZE = 3'd2;
  localparam logic [2:0] PRIM_SIZE   = 3'd2;
  localparam logic [2:0] CONS_SIZE   = 3'd5;

  // Zero marks an unknown header; the allocator rejects such requests.
  function automatic logic [2:0] obj_size(header_t t);
    case (t)
      HDR_NUMBER:    obj_size = NUMBER_SIZE;
      HDR_CONS:      obj_size = CONS_SIZE;
      HDR_FUNC_PRIM: obj_size = PRIM_SIZE;
      default:       obj_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/heap_alloc_if.sv
// Evaluator-facing request/response bus plus the allocator's memory write port.
interface heap_alloc_if
  import heap_alloc_pkg::*;
();

  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_type;
  logic [ADDR_W-1:0] req_a;
  logic [ADDR_W-1:0] req_b;
  logic              heap_clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_ptr;
  logic              resp_oom;
  logic              busy;
  logic [ADDR_W-1:0] free_ptr;

  modport master (
    output req_valid, req_type, req_a, req_b, heap_clear,
    input  req_ready, mem_we, mem_addr, mem_wdata,
    input  resp_valid, resp_ptr, resp_oom, busy, free_ptr
  );

  modport slave (
    input  req_valid, req_type, req_a, req_b, heap_clear,
    output req_ready, mem_we, mem_addr, mem_wdata,
    output resp_valid, resp_ptr, resp_oom, busy, free_ptr
  );

endinterface

// File: rtl/heap_alloc.sv
// Bump-pointer heap allocator: serialises one object per request into memory,
// one byte per cycle, and returns the header address (or NIL on failure).
module heap_alloc
  import heap_alloc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HEAP_BASE  = DEFAULT_HEAP_BASE,
  parameter logic [ADDR_W-1:0] HEAP_LIMIT = DEFAULT_HEAP_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  heap_alloc_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ALLOC_IDLE;
  localparam logic [1:0] S_WRITE = ALLOC_WRITE;
  localparam logic [1:0] S_RESP  = ALLOC_RESP;

  logic [1:0]        state;
  logic [2:0]        idx;
  logic [2:0]        nxt_idx;
  logic [2:0]        size_q;
  logic [7:0]        typ_q;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] obj_ptr;
  // One extra bit so a completely full heap reads HEAP_LIMIT+1, not a wrap to 0.
  logic [ADDR_W:0]   fp;

  logic [2:0]        req_size;
  logic [ADDR_W:0]   req_end;
  logic              req_fits;
  logic              accept;
  logic [DATA_W-1:0] obj_byte;

  assign accept   = (state == S_IDLE) && bus.req_valid && !bus.heap_clear;
  assign req_size = obj_size(header_t'(bus.req_type));
  assign req_end  = fp + {{(ADDR_W-2){1'b0}}, req_size} - {{ADDR_W{1'b0}}, 1'b1};
  assign req_fits = (req_size != 3'd0) && (req_end <= {1'b0, HEAP_LIMIT});
  assign nxt_idx  = idx + 3'd1;

  assign bus.free_ptr = fp[ADDR_W-1:0];

  // Byte following the one currently on the bus; the header (byte 0) is
  // issued straight from the request at acceptance.
  always_comb begin
    obj_byte = typ_q;
    if (typ_q == HDR_CONS) begin
      case (nxt_idx)
        3'd1:    obj_byte = {4'h0, a_q[11:8]};
        3'd2:    obj_byte = a_q[7:0];
        3'd3:    obj_byte = {4'h0, b_q[11:8]};
        3'd4:    obj_byte = b_q[7:0];
        default: obj_byte = typ_q;
      endcase
    end else if (nxt_idx == 3'd1) begin
      obj_byte = a_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      typ_q   <= bus.req_type;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      size_q  <= req_size;
      obj_ptr <= fp[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= 3'd0;
      fp             <= {1'b0, HEAP_BASE};
      bus.req_ready  <= 1'b1;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_ptr   <= '0;
      bus.resp_oom   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.heap_clear) begin
            fp <= {1'b0, HEAP_BASE};
          end else if (accept) begin
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (req_fits) begin
              state         <= S_WRITE;
              idx           <= 3'd0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= fp[ADDR_W-1:0];
              bus.mem_wdata <= bus.req_type;
            end else begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_ptr   <= NIL;
              bus.resp_oom   <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (idx == size_q - 3'd1) begin
            state          <= S_RESP;
            fp             <= fp + {{(ADDR_W-2){1'b0}}, size_q};
            bus.mem_we     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_ptr   <= obj_ptr;
            bus.resp_oom   <= 1'b0;
          end else begin
            idx           <= nxt_idx;
            bus.mem_addr  <= obj_ptr + {{(ADDR_W-3){1'b0}}, nxt_idx};
            bus.mem_wdata <= obj_byte;
          end
        end

        S_RESP: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_oom   <= 1'b0;
          bus.busy       <= 1'b0;
          bus.req_ready  <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heap_alloc.sv
// Directed bench for heap_alloc: object layouts, OOM, heap_clear and reset mid-write.
module tb_heap_alloc;
  import heap_alloc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  heap_alloc_if bus ();

  heap_alloc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge (cycle 1).
  task automatic issue(input logic [7:0] t, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic exp_write(input string tag, input logic [11:0] ad, input logic [7:0] d);
    chk({tag, "_we"},    bus.mem_we,    32'd1);
    chk({tag, "_addr"},  bus.mem_addr,  ad);
    chk({tag, "_data"},  bus.mem_wdata, d);
    chk({tag, "_busy"},  bus.busy,      32'd1);
    chk({tag, "_ready"}, bus.req_ready, 32'd0);
    step();
  endtask

  task automatic exp_resp(input string tag, input logic [11:0] ptr, input logic oom,
                          input logic [11:0] fptr);
    chk({tag, "_rvalid"}, bus.resp_valid, 32'd1);
    chk({tag, "_rptr"},   bus.resp_ptr,   ptr);
    chk({tag, "_oom"},    bus.resp_oom,   oom);
    chk({tag, "_we"},     bus.mem_we,     32'd0);
    chk({tag, "_fp"},     bus.free_ptr,   fptr);
    step();
    chk({tag, "_rvalid_drop"}, bus.resp_valid, 32'd0);
    chk({tag, "_ready_back"},  bus.req_ready,  32'd1);
    chk({tag, "_busy_drop"},   bus.busy,       32'd0);
  endtask

  task automatic alloc_quiet(input logic [7:0] t, input logic [11:0] a, input logic [11:0] b);
    int k;
    k = 0;
    issue(t, a, b);
    while (!bus.resp_valid && k < 20) begin
      step();
      k++;
    end
    chk("fill_resp", bus.resp_valid, 32'd1);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_type   = 8'h00;
    bus.req_a      = 12'h000;
    bus.req_b      = 12'h000;
    bus.heap_clear = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  bus.req_ready,  32'd1);
    chk("rst_we",     bus.mem_we,     32'd0);
    chk("rst_addr",   bus.mem_addr,   32'h000);
    chk("rst_wdata",  bus.mem_wdata,  32'h00);
    chk("rst_rvalid", bus.resp_valid, 32'd0);
    chk("rst_rptr",   bus.resp_ptr,   32'h000);
    chk("rst_oom",    bus.resp_oom,   32'd0);
    chk("rst_busy",   bus.busy,       32'd0);
    chk("rst_fp",     bus.free_ptr,   32'h100);
    @(negedge clk);
    rst_n = 1'b1;

    // NUMBER 0x2A at 0x100
    issue(HDR_NUMBER, 12'h02A, 12'h000);
    exp_write("num_b0", 12'h100, 8'h00);
    exp_write("num_b1", 12'h101, 8'h2A);
    exp_resp("num", 12'h100, 1'b0, 12'h102);

    // CONS car=0x100 cdr=NIL at 0x102
    issue(HDR_CONS, 12'h100, 12'h000);
    exp_write("cons_b0", 12'h102, 8'h01);
    exp_write("cons_b1", 12'h103, 8'h01);
    exp_write("cons_b2", 12'h104, 8'h00);
    exp_write("cons_b3", 12'h105, 8'h00);
    exp_write("cons_b4", 12'h106, 8'h00);
    exp_resp("cons", 12'h102, 1'b0, 12'h107);

    // FUNC_PRIM CDR at 0x107
    issue(HDR_FUNC_PRIM, {4'h0, PRIM_CDR}, 12'h000);
    exp_write("prim_b0", 12'h107, 8'h02);
    exp_write("prim_b1", 12'h108, 8'h02);
    exp_resp("prim", 12'h107, 1'b0, 12'h109);

    // heap_clear beats a simultaneous request
    @(negedge clk);
    bus.heap_clear = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_type   = HDR_NUMBER;
    bus.req_a      = 12'h077;
    step();
    bus.heap_clear = 1'b0;
    bus.req_valid  = 1'b0;
    chk("clr_we",     bus.mem_we,     32'd0);
    chk("clr_busy",   bus.busy,       32'd0);
    chk("clr_rvalid", bus.resp_valid, 32'd0);
    chk("clr_fp",     bus.free_ptr,   32'h100);
    step();
    chk("clr_we2",     bus.mem_we,     32'd0);
    chk("clr_rvalid2", bus.resp_valid, 32'd0);

    // heap_clear while writing is ignored
    issue(HDR_CONS, 12'h123, 12'h0AB);
    bus.heap_clear = 1'b1;
    exp_write("cw_b0", 12'h100, 8'h01);
    exp_write("cw_b1", 12'h101, 8'h01);
    exp_write("cw_b2", 12'h102, 8'h23);
    exp_write("cw_b3", 12'h103, 8'h00);
    exp_write("cw_b4", 12'h104, 8'hAB);
    bus.heap_clear = 1'b0;
    exp_resp("cw", 12'h100, 1'b0, 12'h105);

    // fill 0x105 -> 0xFFC: 765 CONS (3825 bytes) + 3 NUMBER (6 bytes)
    for (int i = 0; i < 765; i++) alloc_quiet(HDR_CONS, 12'h000, 12'h000);
    for (int i = 0; i < 3; i++) alloc_quiet(HDR_NUMBER, 12'h001, 12'h000);
    chk("fill_fp", bus.free_ptr, 32'hFFC);

    // CONS needs 0xFFC..0x1000: out of memory
    issue(HDR_CONS, 12'h100, 12'h000);
    exp_resp("oom", 12'h000, 1'b1, 12'hFFC);

    // NUMBER fits exactly at 0xFFC..0xFFD
    issue(HDR_NUMBER, 12'h055, 12'h000);
    exp_write("last_b0", 12'hFFC, 8'h00);
    exp_write("last_b1", 12'hFFD, 8'h55);
    exp_resp("last", 12'hFFC, 1'b0, 12'hFFE);

    // unknown header
    issue(8'h07, 12'h000, 12'h000);
    exp_resp("badtype", 12'h000, 1'b1, 12'hFFE);

    // reset during the third CONS write
    @(negedge clk);
    bus.heap_clear = 1'b1;
    step();
    bus.heap_clear = 1'b0;
    chk("rc_clear_fp", bus.free_ptr, 32'h100);
    issue(HDR_CONS, 12'h100, 12'h000);
    exp_write("rc_b0", 12'h100, 8'h01);
    exp_write("rc_b1", 12'h101, 8'h01);
    chk("rc_b2_we",   bus.mem_we,   32'd1);
    chk("rc_b2_addr", bus.mem_addr, 32'h102);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rc_we",     bus.mem_we,     32'd0);
    chk("rc_addr",   bus.mem_addr,   32'h000);
    chk("rc_busy",   bus.busy,       32'd0);
    chk("rc_ready",  bus.req_ready,  32'd1);
    chk("rc_rvalid", bus.resp_valid, 32'd0);
    chk("rc_fp",     bus.free_ptr,   32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rc_no_resp", bus.resp_valid, 32'd0);
      chk("rc_no_we",   bus.mem_we,     32'd0);
    end
    chk("rc_fp_after", bus.free_ptr, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
